// File: rtl/pipe_ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register and its hazard comparator.
//   - default datapath / register-number widths
//   - ALU opcode constants (bits [2:0] of aluc)
//   - memory/writeback control bundle
//   - signed add/sub overflow helper
package pipe_ex_mem_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RW_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } ctrl_t;

  // Signed overflow from operand/result sign bits only.
  function automatic logic ovf_check(input logic [2:0] op, input logic a_msb,
                                     input logic b_msb, input logic r_msb);
    logic ovf;
    ovf = 1'b0;
    if (op == ALU_ADD) begin
      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end else if (op == ALU_SUB) begin
      ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/pipe_ex_mem_hazard_cmp.sv
// Forwarding / load-use comparator for a registered pipeline stage.
// Purely combinational; also instantiated by the MEM/WB stage.
// Ports:
//   i_valid, i_wreg, i_m2reg, i_rn : registered state of the producing stage
//   i_rs, i_rt                     : source registers of the instruction in ID
//   i_stall                        : pipe frozen; suppresses load-use request
//   o_fwd_rs, o_fwd_rt             : ID operand must take the stage result
//   o_lu_stall                     : load-use hazard, ID stalls one cycle
module pipe_ex_mem_hazard_cmp
  import pipe_ex_mem_pkg::*;
#(
  parameter int unsigned RW = RW_DEF
) (
  input  logic          i_valid,
  input  logic          i_wreg,
  input  logic          i_m2reg,
  input  logic [RW-1:0] i_rn,
  input  logic [RW-1:0] i_rs,
  input  logic [RW-1:0] i_rt,
  input  logic          i_stall,
  output logic          o_fwd_rs,
  output logic          o_fwd_rt,
  output logic          o_lu_stall
);

  logic w_nz;
  logic w_hit_rs;
  logic w_hit_rt;
  logic w_alu_wr;

  always_comb begin
    // Register 0 is hard-wired zero and never a hazard source.
    w_nz     = (i_rn != '0);
    w_hit_rs = w_nz && (i_rn == i_rs);
    w_hit_rt = w_nz && (i_rn == i_rt);
    // A load's data is not available yet, so it never forwards from here.
    w_alu_wr = i_valid && i_wreg && !i_m2reg;

    o_fwd_rs   = w_alu_wr && w_hit_rs;
    o_fwd_rt   = w_alu_wr && w_hit_rt;
    o_lu_stall = !i_stall && i_valid && i_m2reg && (w_hit_rs || w_hit_rt);
  end

endmodule

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register behind the integer ALU.
// Captures result, zero flag, store data, destination and control each cycle; holds on
// stall, bubbles on flush (flush wins over stall), and reports forwarding / load-use
// hazards to ID.
// Optional feature: define PIPE_EX_MEM_OVF_EN to register a signed add/sub overflow
// trap flag (o_ovf) that also suppresses the trapping instruction's wreg/wmem.
// Ports:
//   i_clk, i_rst (async, active-high), i_stall, i_flush
//   i_ex_*        : EX-stage instruction fields
//   i_id_rs/rt    : ID-stage source registers
//   o_mm_*        : registered MEM-stage fields
//   o_fwd_rs/rt, o_lu_stall : hazard outputs
//   o_ovf         : registered overflow exception flag
module pipe_ex_mem
  import pipe_ex_mem_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic          i_ex_valid,
  input  logic [DW-1:0] i_ex_r,
  input  logic          i_ex_z,
  input  logic [DW-1:0] i_ex_a,
  input  logic [DW-1:0] i_ex_b,
  input  logic [3:0]    i_ex_aluc,
  input  logic [RW-1:0] i_ex_rn,
  input  logic          i_ex_wreg,
  input  logic          i_ex_m2reg,
  input  logic          i_ex_wmem,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  output logic          o_mm_valid,
  output logic [DW-1:0] o_mm_r,
  output logic          o_mm_z,
  output logic [DW-1:0] o_mm_sd,
  output logic [RW-1:0] o_mm_rn,
  output logic          o_mm_wreg,
  output logic          o_mm_m2reg,
  output logic          o_mm_wmem,
  output logic          o_fwd_rs,
  output logic          o_fwd_rt,
  output logic          o_lu_stall,
  output logic          o_ovf
);

  logic          r_valid;
  logic [DW-1:0] r_r;
  logic          r_z;
  logic [DW-1:0] r_sd;
  logic [RW-1:0] r_rn;
  ctrl_t         r_ctrl;
  logic          r_ovf;

  logic          w_ovf;
  ctrl_t         w_ctrl;

`ifdef PIPE_EX_MEM_OVF_EN
  logic w_unused_ovf;
  assign w_unused_ovf = ^{i_ex_a[DW-2:0], i_ex_aluc[3]};
  assign w_ovf = i_ex_valid &&
                 ovf_check(i_ex_aluc[2:0], i_ex_a[DW-1], i_ex_b[DW-1], i_ex_r[DW-1]);
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ^{i_ex_a, i_ex_aluc};
  assign w_ovf = 1'b0;
`endif

  // Control bits are qualified by valid; a trapping instruction loses its side effects.
  always_comb begin
    w_ctrl.wreg  = i_ex_wreg && i_ex_valid && !w_ovf;
    w_ctrl.m2reg = i_ex_m2reg && i_ex_valid;
    w_ctrl.wmem  = i_ex_wmem && i_ex_valid && !w_ovf;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_r     <= '0;
      r_z     <= 1'b0;
      r_sd    <= '0;
      r_rn    <= '0;
      r_ctrl  <= '0;
      r_ovf   <= 1'b0;
    end else if (i_flush) begin
      // Bubble: datapath fields are don't-care and simply keep their value.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_ovf   <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_ex_valid;
      r_r     <= i_ex_r;
      r_z     <= i_ex_z;
      r_sd    <= i_ex_b;
      r_rn    <= i_ex_rn;
      r_ctrl  <= w_ctrl;
      r_ovf   <= w_ovf;
    end
  end

  assign o_mm_valid = r_valid;
  assign o_mm_r     = r_r;
  assign o_mm_z     = r_z;
  assign o_mm_sd    = r_sd;
  assign o_mm_rn    = r_rn;
  assign o_mm_wreg  = r_ctrl.wreg;
  assign o_mm_m2reg = r_ctrl.m2reg;
  assign o_mm_wmem  = r_ctrl.wmem;
  assign o_ovf      = r_ovf;

  pipe_ex_mem_hazard_cmp #(
    .RW(RW)
  ) u_hazard_cmp (
    .i_valid   (r_valid),
    .i_wreg    (r_ctrl.wreg),
    .i_m2reg   (r_ctrl.m2reg),
    .i_rn      (r_rn),
    .i_rs      (i_id_rs),
    .i_rt      (i_id_rt),
    .i_stall   (i_stall),
    .o_fwd_rs  (o_fwd_rs),
    .o_fwd_rt  (o_fwd_rt),
    .o_lu_stall(o_lu_stall)
  );

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Directed self-checking bench for pipe_ex_mem.
module tb_pipe_ex_mem;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [DW-1:0] ex_r;
  logic          ex_z;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_aluc;
  logic [RW-1:0] ex_rn;
  logic          ex_wreg;
  logic          ex_m2reg;
  logic          ex_wmem;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          mm_valid;
  logic [DW-1:0] mm_r;
  logic          mm_z;
  logic [DW-1:0] mm_sd;
  logic [RW-1:0] mm_rn;
  logic          mm_wreg;
  logic          mm_m2reg;
  logic          mm_wmem;
  logic          fwd_rs;
  logic          fwd_rt;
  logic          lu_stall;
  logic          ovf;

  int n_pass  = 0;
  int n_total = 0;

  pipe_ex_mem #(
    .DW(DW),
    .RW(RW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_stall   (stall),
    .i_flush   (flush),
    .i_ex_valid(ex_valid),
    .i_ex_r    (ex_r),
    .i_ex_z    (ex_z),
    .i_ex_a    (ex_a),
    .i_ex_b    (ex_b),
    .i_ex_aluc (ex_aluc),
    .i_ex_rn   (ex_rn),
    .i_ex_wreg (ex_wreg),
    .i_ex_m2reg(ex_m2reg),
    .i_ex_wmem (ex_wmem),
    .i_id_rs   (id_rs),
    .i_id_rt   (id_rt),
    .o_mm_valid(mm_valid),
    .o_mm_r    (mm_r),
    .o_mm_z    (mm_z),
    .o_mm_sd   (mm_sd),
    .o_mm_rn   (mm_rn),
    .o_mm_wreg (mm_wreg),
    .o_mm_m2reg(mm_m2reg),
    .o_mm_wmem (mm_wmem),
    .o_fwd_rs  (fwd_rs),
    .o_fwd_rt  (fwd_rt),
    .o_lu_stall(lu_stall),
    .o_ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ex(input logic v, input logic [DW-1:0] r, input logic z,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] aluc, input logic [RW-1:0] rn,
                        input logic wreg, input logic m2reg, input logic wmem);
    ex_valid = v;
    ex_r     = r;
    ex_z     = z;
    ex_a     = a;
    ex_b     = b;
    ex_aluc  = aluc;
    ex_rn    = rn;
    ex_wreg  = wreg;
    ex_m2reg = m2reg;
    ex_wmem  = wmem;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_rs = '0; id_rt = '0;
    set_ex(1'b0, '0, 1'b0, '0, '0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    n_total++;
    if ({mm_valid, mm_wreg, mm_m2reg, mm_wmem, mm_z, ovf, mm_r, mm_sd, mm_rn} !== '0)
      $display("FAIL reset_state: valid=%b wreg=%b r=%h sd=%h rn=%0d ovf=%b",
               mm_valid, mm_wreg, mm_r, mm_sd, mm_rn, ovf);
    else n_pass++;

    // Load live data, then reset asynchronously mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    set_ex(1'b1, 32'h0000_0055, 1'b1, '0, 32'h66, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (mm_valid !== 1'b1 || mm_wreg !== 1'b1 || mm_r !== 32'h55)
      $display("FAIL pre_reset_load: valid=%b wreg=%b r=%h want 1 1 00000055",
               mm_valid, mm_wreg, mm_r);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (mm_valid !== 1'b0 || mm_wreg !== 1'b0 || mm_r !== '0)
      $display("FAIL async_reset: valid=%b wreg=%b r=%h want 0 0 0", mm_valid, mm_wreg, mm_r);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    set_ex(1'b1, 32'h1234_5678, 1'b0, '0, '0, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (mm_r !== 32'h1234_5678 || mm_valid !== 1'b1)
      $display("FAIL first_after_reset: r=%h valid=%b want 12345678 1", mm_r, mm_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_ex(1'b1, 32'hA, 1'b1, '0, 32'hCAFE_F00D, 4'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (mm_r !== 32'hA || mm_z !== 1'b1 || mm_sd !== 32'hCAFE_F00D || mm_rn !== 5'd7)
      $display("FAIL load_fields: r=%h z=%b sd=%h rn=%0d want a 1 cafef00d 7",
               mm_r, mm_z, mm_sd, mm_rn);
    else n_pass++;
    @(negedge clk);
    stall = 1'b1;
    set_ex(1'b1, 32'hB, 1'b0, '0, 32'h1, 4'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (mm_r !== 32'hA || mm_rn !== 5'd7)
        $display("FAIL stall_hold[%0d]: r=%h rn=%0d want a 7", i, mm_r, mm_rn);
      else n_pass++;
    end
    @(negedge clk);
    stall = 1'b0;
    tick();
    n_total++;
    if (mm_r !== 32'hB || mm_rn !== 5'd9)
      $display("FAIL stall_release: r=%h rn=%0d want b 9", mm_r, mm_rn);
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    set_ex(1'b1, 32'h100, 1'b0, '0, 32'h77, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    n_total++;
    if (mm_wmem !== 1'b1 || mm_valid !== 1'b1)
      $display("FAIL store_load: wmem=%b valid=%b want 1 1", mm_wmem, mm_valid);
    else n_pass++;
    @(negedge clk);
    flush = 1'b1; stall = 1'b1;
    tick();
    n_total++;
    if (mm_valid !== 1'b0 || mm_wmem !== 1'b0 || mm_wreg !== 1'b0 || mm_m2reg !== 1'b0)
      $display("FAIL flush_stall: valid=%b wmem=%b wreg=%b m2reg=%b want 0 0 0 0",
               mm_valid, mm_wmem, mm_wreg, mm_m2reg);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    set_ex(1'b1, 32'h200, 1'b0, '0, 32'h88, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    n_total++;
    if (mm_wmem !== 1'b1 || mm_valid !== 1'b1 || mm_sd !== 32'h88)
      $display("FAIL after_flush_store: wmem=%b valid=%b sd=%h want 1 1 88",
               mm_wmem, mm_valid, mm_sd);
    else n_pass++;
    // An invalid instruction must not carry write enables.
    @(negedge clk);
    set_ex(1'b0, 32'h300, 1'b0, '0, '0, 4'd0, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    n_total++;
    if (mm_valid !== 1'b0 || mm_wreg !== 1'b0 || mm_wmem !== 1'b0 || mm_m2reg !== 1'b0)
      $display("FAIL invalid_gating: valid=%b wreg=%b wmem=%b m2reg=%b want 0 0 0 0",
               mm_valid, mm_wreg, mm_wmem, mm_m2reg);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_ex(1'b1, 32'h5, 1'b0, '0, '0, 4'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    id_rs = 5'd5; id_rt = 5'd5;
    tick();
    n_total++;
    if (fwd_rs !== 1'b1 || fwd_rt !== 1'b1 || lu_stall !== 1'b0)
      $display("FAIL fwd_both: rs=%b rt=%b lu=%b want 1 1 0", fwd_rs, fwd_rt, lu_stall);
    else n_pass++;
    id_rt = 5'd6;
    #1;
    n_total++;
    if (fwd_rs !== 1'b1 || fwd_rt !== 1'b0)
      $display("FAIL fwd_rs_only: rs=%b rt=%b want 1 0", fwd_rs, fwd_rt);
    else n_pass++;
    @(negedge clk);
    set_ex(1'b1, 32'h5, 1'b0, '0, '0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    id_rs = 5'd0; id_rt = 5'd0;
    tick();
    n_total++;
    if (fwd_rs !== 1'b0 || fwd_rt !== 1'b0)
      $display("FAIL fwd_r0: rs=%b rt=%b want 0 0", fwd_rs, fwd_rt);
    else n_pass++;
    @(negedge clk);
    set_ex(1'b1, 32'h40, 1'b0, '0, '0, 4'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    id_rs = 5'd5; id_rt = 5'd9;
    tick();
    n_total++;
    if (lu_stall !== 1'b1 || fwd_rs !== 1'b0 || fwd_rt !== 1'b0)
      $display("FAIL load_use: lu=%b rs=%b rt=%b want 1 0 0", lu_stall, fwd_rs, fwd_rt);
    else n_pass++;
    id_rs = 5'd9; id_rt = 5'd5;
    #1;
    n_total++;
    if (lu_stall !== 1'b1)
      $display("FAIL load_use_rt: lu=%b want 1", lu_stall);
    else n_pass++;
    stall = 1'b1;
    #1;
    n_total++;
    if (lu_stall !== 1'b0)
      $display("FAIL load_use_stalled: lu=%b want 0", lu_stall);
    else n_pass++;
    @(negedge clk);
    stall = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2;
    #1;
    n_total++;
    if (lu_stall !== 1'b0)
      $display("FAIL load_use_nohit: lu=%b want 0", lu_stall);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic exp_ovf;
`ifdef PIPE_EX_MEM_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    set_ex(1'b1, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 32'h1, 4'b0000, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ovf !== exp_ovf || mm_wreg !== !exp_ovf || mm_r !== 32'h8000_0000)
      $display("FAIL add_ovf: ovf=%b wreg=%b r=%h want %b %b 80000000",
               ovf, mm_wreg, mm_r, exp_ovf, !exp_ovf);
    else n_pass++;
    @(negedge clk);
    set_ex(1'b1, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000, 32'h1, 4'b0100, 5'd3, 1'b0, 1'b0, 1'b1);
    tick();
    n_total++;
    if (ovf !== exp_ovf || mm_wmem !== !exp_ovf)
      $display("FAIL sub_ovf: ovf=%b wmem=%b want %b %b", ovf, mm_wmem, exp_ovf, !exp_ovf);
    else n_pass++;
    @(negedge clk);
    flush = 1'b1;
    tick();
    n_total++;
    if (ovf !== 1'b0)
      $display("FAIL flush_ovf: ovf=%b want 0", ovf);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    set_ex(1'b1, 32'h2, 1'b0, 32'h5, 32'h3, 4'b0100, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ovf !== 1'b0 || mm_wreg !== 1'b1)
      $display("FAIL sub_no_ovf: ovf=%b wreg=%b want 0 1", ovf, mm_wreg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush_stall();
    test_forwarding();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ex_mem.md
Name: pipe_ex_mem

Overview:
- EX/MEM pipeline register directly downstream of the EX-stage integer ALU.
- Captures the ALU result, zero flag, store data, destination register and memory/writeback control bits every cycle.
- Holds its contents while the data cache or TLB stalls the pipe, and inserts a bubble on flush.
- Supplies forwarding-hit and load-use hazard signals back to the ID stage.

Parameters:
- DW, 32, datapath width of result and store data.
- RW, 5, register-number width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold request from the MEM stage (cache/TLB miss).
- flush  in  1  cancel the instruction currently entering MEM (exception/redirect).
- ex_valid  in  1  EX stage holds a live instruction.
- ex_r  in  DW  ALU result.
- ex_z  in  1  ALU zero flag.
- ex_a  in  DW  ALU operand a; used only by the optional overflow check.
- ex_b  in  DW  ALU operand b; also the store data.
- ex_aluc  in  4  ALU opcode; used only by the optional overflow check.
- ex_rn  in  RW  destination register.
- ex_wreg  in  1  writes the register file.
- ex_m2reg  in  1  load (result comes from memory).
- ex_wmem  in  1  store.
- id_rs  in  RW  source register rs of the instruction in ID.
- id_rt  in  RW  source register rt of the instruction in ID.
- mm_valid  out  1  registered valid.
- mm_r  out  DW  registered result / memory address.
- mm_z  out  1  registered zero flag.
- mm_sd  out  DW  registered store data.
- mm_rn  out  RW  registered destination register.
- mm_wreg  out  1  registered write-enable, gated by valid.
- mm_m2reg  out  1  registered load flag.
- mm_wmem  out  1  registered store flag, gated by valid.
- fwd_rs  out  1  ID rs must take mm_r.
- fwd_rt  out  1  ID rt must take mm_r.
- lu_stall  out  1  load-use hazard; ID must stall one cycle.
- ovf  out  1  registered overflow exception flag.

Behaviour:
- Reset (async, rst=1): mm_valid, mm_wreg, mm_m2reg, mm_wmem, mm_z and ovf go to 0; mm_r, mm_sd and mm_rn go to 0. Effect is immediate, without waiting for a clock edge.
- Latency: one cycle from ex_* to mm_*.
- Edge priority on each rising edge, highest first: rst, then flush, then stall, then load.
  - flush: mm_valid, mm_wreg, mm_wmem, mm_m2reg and ovf go to 0 (bubble); datapath fields are don't-care, and the implementation keeps them unchanged.
  - stall and not flush: all registers hold.
  - otherwise: load all fields. mm_valid takes ex_valid; mm_wreg/mm_wmem/mm_m2reg take ex_* ANDed with ex_valid.
- flush and stall together: flush wins. A cancelled instruction must not linger.
- Forwarding (combinational from registered state):
  - fwd_rs = mm_valid & mm_wreg & ~mm_m2reg & (mm_rn != 0) & (mm_rn == id_rs). fwd_rt is the same with id_rt.
  - Register 0 never forwards.
- Load-use: lu_stall = mm_valid & mm_m2reg & (mm_rn != 0) & (mm_rn == id_rs | mm_rn == id_rt).
  - Forced 0 while stall=1, because the pipe is already frozen.
  - Never asserted together with the fwd_* flags for the same register.
- The block does no width extension or arithmetic; result and store data pass through bit-exact.
- A reset deasserted mid-stall leaves the register empty (mm_valid=0). The first live instruction is captured on the first edge with stall=0.

Optional Feature:
- Macro: PIPE_EX_MEM_OVF_EN.
- With the macro defined:
  - On load, ovf is registered for signed add (ex_aluc[2:0]=000) when ex_a[31]==ex_b[31] and ex_r[31]!=ex_a[31].
  - ovf is registered for signed sub (ex_aluc[2:0]=100) when ex_a[31]!=ex_b[31] and ex_r[31]!=ex_a[31].
  - Both are qualified by ex_valid.
  - When ovf is set, mm_wreg and mm_wmem load as 0, so a trapping instruction has no side effects.
- Without the macro: ovf is tied to 0, and ex_a and ex_aluc are unused.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD=000, ALU_SUB=100 on bits [2:0]), DW/RW defaults, and a control-bundle typedef {wreg, m2reg, wmem}.
- Sub-module hazard_cmp: combinational equality/nonzero comparator producing fwd_rs, fwd_rt and lu_stall. It is reused by the MEM/WB stage.

Test Plan:
- Reset mid-operation: reset with rst=1 while registers hold data; mm_valid=0 and mm_wreg=0 immediately, before any edge. The first edge after release with ex_valid=1, ex_r=0x12345678 gives mm_r=0x12345678.
- Stall hold: load ex_r=0xA, then stall=1 for 3 cycles while ex_r changes to 0xB. mm_r stays 0xA; after stall drops, mm_r=0xB.
- Flush+stall together: mm_valid=0 and mm_wmem=0 on the next edge; then flush=0 and stall=0 with a new store gives mm_wmem=1.
- Forwarding: mm_rn=5, mm_wreg=1, id_rs=5, id_rt=5 gives fwd_rs=1, fwd_rt=1. With mm_rn=0, both are 0. With mm_m2reg=1, lu_stall=1 and fwd_rs=0; adding stall=1 gives lu_stall=0.
- Overflow (macro defined): ex_a=0x7FFFFFFF, ex_b=1, ex_r=0x80000000, aluc=0000, wreg=1 gives ovf=1 and mm_wreg=0. With ex_a=5, ex_b=3, ex_r=2, aluc=0100: ovf=0, mm_wreg=1.
- Without macro: the same overflow stimulus gives ovf=0 and mm_wreg=1.
